// File: rtl/i2c_apb_arb_pkg.sv
// Shared types and defaults for the I2C-core APB arbiter.
// Contents: FSM state enum, default parameter values, grant-index helper.
package i2c_apb_arb_pkg;

    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

    // One transaction in flight: accept -> APB setup -> APB access -> response.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Requester index to one-hot strobe vector.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-way round-robin grant selection (purely combinational).
// Ports:
//   valid   [1:0] per-requester request
//   last          index of the requester granted most recently
//   grant_c [1:0] one-hot grant, zero when nothing is requested
//   index_c       index of the granted requester
module i2c_rr_arb2
    import i2c_apb_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant_c,
    output logic       index_c
);

    // Under contention the requester not served last wins.
    always_comb begin
        grant_c = 2'b00;
        index_c = 1'b0;
        case (valid)
            2'b01: begin
                grant_c = 2'b01;
                index_c = 1'b0;
            end
            2'b10: begin
                grant_c = 2'b10;
                index_c = 1'b1;
            end
            2'b11: begin
                index_c = ~last;
                grant_c = idx_to_onehot(~last);
            end
            default: begin
                grant_c = 2'b00;
                index_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/i2c_apb_arbiter.sv
// Arbitrates two command requesters onto a single APB master port that
// drives the I2C core register slave. One transaction is in flight at a time.
// Optional feature: define I2C_APB_ARB_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYC wait cycles and return rsp_err_o=1.
// Ports:
//   pclk_i, preset_i          clock, synchronous active-high reset
//   req_valid_i/req_write_i   per-requester command valid / direction
//   req_addr_i/req_wdata_i    per-requester address / write data, slice r
//   req_ready_o               one-cycle accept pulse per requester
//   rsp_valid_o               one-cycle response pulse per requester
//   rsp_rdata_o, rsp_err_o    response data / timeout flag, held between responses
//   psel_o ... pready_i       APB master interface
module i2c_apb_arbiter
    import i2c_apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                pclk_i,
    input  logic                preset_i,
    input  logic [1:0]          req_valid_i,
    input  logic [1:0]          req_write_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    output logic [1:0]          req_ready_o,
    output logic [1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic [DATA_W-1:0]   pwdata_o,
    input  logic [DATA_W-1:0]   prdata_i,
    input  logic                pready_i
);

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic                cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [1:0]          req_ready_q, req_ready_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;

    logic [1:0]          arb_grant_c;
    logic                arb_index_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;

`ifdef I2C_APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                rsp_err_q, rsp_err_d;
    logic                timeout_c;

    // Last permitted wait cycle of ACCESS with pready_i still low.
    assign timeout_c = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign rsp_err_o = rsp_err_q;
`else
    logic                unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign rsp_err_o      = 1'b0;
`endif

    i2c_rr_arb2 u_rr_arb (
        .valid   (req_valid_i),
        .last    (last_q),
        .grant_c (arb_grant_c),
        .index_c (arb_index_c)
    );

    // Command fields of the requester that wins this cycle.
    assign sel_addr_c  = arb_index_c ? req_addr_i[2*ADDR_W-1 -: ADDR_W]
                                     : req_addr_i[ADDR_W-1:0];
    assign sel_wdata_c = arb_index_c ? req_wdata_i[2*DATA_W-1 -: DATA_W]
                                     : req_wdata_i[DATA_W-1:0];

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        req_ready_d = 2'b00;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
`ifdef I2C_APB_ARB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (arb_grant_c != 2'b00) begin
                    req_ready_d = arb_grant_c;
                    grant_d     = arb_index_c;
                    last_d      = arb_index_c;
                    cmd_write_d = req_write_i[arb_index_c];
                    cmd_addr_d  = sel_addr_c;
                    cmd_wdata_d = sel_wdata_c;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef I2C_APB_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    // Writes return zero data.
                    rsp_rdata_d = cmd_write_q ? '0 : prdata_i;
                    rsp_valid_d = idx_to_onehot(grant_q);
                    state_d     = ST_RESP;
`ifdef I2C_APB_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (timeout_c) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = idx_to_onehot(grant_q);
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // APB strobes follow the phase being entered so they stay registered.
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
    end

    // State and output registers.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            req_ready_q <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
`ifdef I2C_APB_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
`ifdef I2C_APB_ARB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = cmd_write_q;
    assign paddr_o     = cmd_addr_q;
    assign pwdata_o    = cmd_wdata_q;

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Bench for i2c_apb_arbiter: transaction-level timing model (accept, APB
// phases and response placed by latency arithmetic), directed scenarios with
// literal expectations, then randomized requesters, wait states and resets.
module tb_i2c_apb_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, pwdata, prdata;
    logic            rsp_err, psel, penable, pwrite, pready;
    logic [AW-1:0]   paddr;

    always #5 clk = ~clk;

    i2c_apb_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .pclk_i      (clk),
        .preset_i    (rst),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .pready_i    (pready)
    );

    // Model: a transaction is a timeline t=0 accept/SETUP, t=1..acc ACCESS,
    // t=acc+1 response, t=acc+2 idle again.
    bit            m_busy;
    int            m_t, m_w, m_acc, m_grant;
    int            m_last = 1;
    bit            m_err;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    bit            just_reset;

    int  cyc, checks, passed;
    int  forced_w = -1;
    bit  auto_req, hold_both, inj_rst, force_rd_en;
    logic [DW-1:0] force_rd;

    int            dut_ready_cyc, dut_rsp_cyc, dut_rsp_cnt, access_cnt;
    logic [1:0]    ready_log[$];
    logic [1:0]    last_rv;
    logic [AW-1:0] seen_paddr;
    logic [DW-1:0] seen_pwdata;
    logic          seen_pwrite;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [1:0] oh(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 12) return r % 4;
        if (r < 19) return 4 + (r % 3);
        return 20;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_busy = 0; m_t = 0; m_last = 1; m_grant = 0;
            exp_rdata = '0; exp_err = 1'b0;
            m_wr = 1'b0; m_addr = '0; m_wd = '0;
            just_reset = 1;
            return;
        end
        just_reset = 0;
        if (m_busy) begin
            m_t++;
            if (m_t == m_acc + 1) begin
                if (m_err) begin
                    exp_rdata = '0; exp_err = 1'b1;
                end else begin
                    exp_rdata = m_wr ? '0 : prdata; exp_err = 1'b0;
                end
            end
            if (m_t == m_acc + 2) m_busy = 0;
        end else if (req_valid != 2'b00) begin
            if (req_valid == 2'b11) m_grant = 1 - m_last;
            else m_grant = req_valid[1] ? 1 : 0;
            m_last = m_grant;
            m_wr   = req_write[m_grant];
            m_addr = req_addr[m_grant*AW +: AW];
            m_wd   = req_wdata[m_grant*DW +: DW];
            m_w    = (forced_w >= 0) ? forced_w : pick_wait();
`ifdef I2C_APB_ARB_TIMEOUT_EN
            m_err = (m_w >= int'(TO));
            m_acc = m_err ? int'(TO) : m_w + 1;
`else
            m_err = 0;
            m_acc = m_w + 1;
`endif
            m_busy = 1;
            m_t    = 0;
        end
    endtask

    task automatic compare();
        logic       e_psel, e_pen;
        logic [1:0] e_ready, e_rv;
        e_psel  = m_busy && (m_t <= m_acc);
        e_pen   = m_busy && (m_t >= 1) && (m_t <= m_acc);
        e_ready = (m_busy && m_t == 0) ? oh(m_grant) : 2'b00;
        e_rv    = (m_busy && m_t == m_acc + 1) ? oh(m_grant) : 2'b00;
        chk("psel", 32'(psel), 32'(e_psel));
        chk("penable", 32'(penable), 32'(e_pen));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (e_psel || just_reset) begin
            chk("paddr", 32'(paddr), 32'(m_addr));
            chk("pwdata", 32'(pwdata), 32'(m_wd));
            chk("pwrite", 32'(pwrite), 32'(m_wr));
        end
        if (req_ready != 2'b00) begin
            dut_ready_cyc = cyc;
            ready_log.push_back(req_ready);
        end
        if (rsp_valid != 2'b00) begin
            dut_rsp_cyc = cyc;
            dut_rsp_cnt++;
            last_rv = rsp_valid;
        end
        if (psel && penable) begin
            seen_paddr  = paddr;
            seen_pwdata = pwdata;
            seen_pwrite = pwrite;
            access_cnt++;
        end
    endtask

    task automatic drive();
        rst = 1'b0;
        if (m_busy && m_t >= 1 && m_t <= m_acc) begin
            pready = (m_t == m_w + 1);
            prdata = (pready && force_rd_en) ? force_rd : DW'($urandom);
        end else begin
            pready = 1'($urandom_range(0, 1));
            prdata = DW'($urandom);
        end
        for (int r = 0; r < 2; r++) begin
            if (req_ready[r] && !hold_both) req_valid[r] = 1'b0;
            if (auto_req && !req_valid[r] && $urandom_range(0, 2) == 0) begin
                req_valid[r] = 1'b1;
                req_write[r] = 1'($urandom_range(0, 1));
                req_addr[r*AW +: AW]  = AW'($urandom);
                req_wdata[r*DW +: DW] = DW'($urandom);
            end
        end
        if (inj_rst && m_busy && m_t >= 1 && m_t <= m_acc && $urandom_range(0, 24) == 0)
            rst = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare();
        drive();
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && m_busy; i++) step();
        chk("wait_idle", 32'(m_busy), 32'd0);
    endtask

    task automatic wait_rsp(input int max);
        int start;
        bit got;
        start = dut_rsp_cnt;
        for (int i = 0; i < max && dut_rsp_cnt == start; i++) step();
        got = (dut_rsp_cnt != start);
        chk("wait_rsp", 32'(got), 32'd1);
    endtask

    initial begin
        int saved;
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0;
        step();
        rst = 1'b1;
        step();
        chk("lit_reset_psel", 32'(psel), 32'd0);
        chk("lit_reset_ready", 32'(req_ready), 32'd0);
        chk("lit_reset_rdata", 32'(rsp_rdata), 32'd0);

        // Single write from requester 0, zero wait states.
        req_valid = 2'b01; req_write = 2'b01; req_addr[7:0] = 8'h04; req_wdata[7:0] = 8'hA5;
        forced_w = 0; access_cnt = 0;
        wait_rsp(20);
        chk("lit_wr_paddr", 32'(seen_paddr), 32'h04);
        chk("lit_wr_pwdata", 32'(seen_pwdata), 32'hA5);
        chk("lit_wr_pwrite", 32'(seen_pwrite), 32'd1);
        chk("lit_wr_rsp", 32'(last_rv), 32'b01);
        chk("lit_wr_err", 32'(rsp_err), 32'd0);
        chk("lit_wr_access", 32'(access_cnt), 32'd1);
        chk("lit_wr_latency", 32'(dut_rsp_cyc - dut_ready_cyc), 32'd2);

        // Read from requester 1 with three wait states.
        wait_idle(20);
        req_valid = 2'b10; req_write = 2'b00; req_addr[15:8] = 8'h08;
        forced_w = 3; force_rd_en = 1; force_rd = 8'h3C; access_cnt = 0;
        wait_rsp(30);
        chk("lit_rd_rsp", 32'(last_rv), 32'b10);
        chk("lit_rd_rdata", 32'(rsp_rdata), 32'h3C);
        chk("lit_rd_access", 32'(access_cnt), 32'd4);
        chk("lit_rd_latency", 32'(dut_rsp_cyc - dut_ready_cyc), 32'd5);
        force_rd_en = 0;

        // Slave never ready for a long time.
        wait_idle(20);
        req_valid = 2'b01; req_write = 2'b00; req_addr[7:0] = 8'h10;
        forced_w = 20; access_cnt = 0;
`ifdef I2C_APB_ARB_TIMEOUT_EN
        wait_rsp(40);
        chk("lit_to_err", 32'(rsp_err), 32'd1);
        chk("lit_to_rdata", 32'(rsp_rdata), 32'd0);
        chk("lit_to_access", 32'(access_cnt), 32'(TO));
        chk("lit_to_latency", 32'(dut_rsp_cyc - dut_ready_cyc), 32'(TO + 1));
`else
        saved = dut_rsp_cnt;
        repeat (16) step();
        chk("lit_hold_psel", 32'(psel), 32'd1);
        chk("lit_hold_penable", 32'(penable), 32'd1);
        chk("lit_hold_norsp", 32'(dut_rsp_cnt), 32'(saved));
        wait_rsp(40);
        chk("lit_hold_access", 32'(access_cnt), 32'd21);
        chk("lit_hold_err", 32'(rsp_err), 32'd0);
`endif

        // Continuous contention from reset alternates grants.
        wait_idle(40);
        rst = 1'b1;
        step();
        ready_log.delete();
        hold_both = 1; forced_w = 0;
        req_valid = 2'b11; req_write = 2'b11; req_addr = 16'h3322; req_wdata = 16'h5544;
        for (int i = 0; i < 40 && ready_log.size() < 4; i++) step();
        chk("lit_rr_count", 32'(ready_log.size()), 32'd4);
        chk("lit_rr_g0", 32'(ready_log[0]), 32'b01);
        chk("lit_rr_g1", 32'(ready_log[1]), 32'b10);
        chk("lit_rr_g2", 32'(ready_log[2]), 32'b01);
        chk("lit_rr_g3", 32'(ready_log[3]), 32'b10);

        // Reset while in ACCESS drops the command and restores the pointer.
        rst = 1'b1;
        step();
        ready_log.delete();
        forced_w = 6;
        for (int i = 0; i < 10 && !(psel && penable); i++) step();
        chk("lit_rst_in_access", 32'(psel && penable), 32'd1);
        saved = dut_rsp_cnt;
        rst = 1'b1;
        step();
        chk("lit_rst_psel", 32'(psel), 32'd0);
        chk("lit_rst_penable", 32'(penable), 32'd0);
        for (int i = 0; i < 10 && ready_log.size() < 2; i++) step();
        chk("lit_rst_first", 32'(ready_log[0]), 32'b01);
        chk("lit_rst_regrant", 32'(ready_log[1]), 32'b01);
        chk("lit_rst_norsp", 32'(dut_rsp_cnt), 32'(saved));

        // Randomized traffic with random wait states and occasional resets.
        hold_both = 0; forced_w = -1; req_valid = 2'b00;
        auto_req = 1; inj_rst = 1;
        repeat (3000) step();
        auto_req = 0; inj_rst = 0;
        wait_idle(60);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
